// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: two-level walk on a TLB miss, one PTE read at a time.
// Optional build macro SV32_PTW_AD_CHECK_EN makes leaves with A=0 (or D=0 on a store) fault.
module sv32_ptw #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] satp_ppn_i,
  input  logic        walk_req_i,
  input  logic [31:0] walk_vaddr_i,
  input  logic        walk_store_i,
  input  logic        flush_i,
  output logic        walk_busy_o,
  output logic        walk_done_o,
  output logic        walk_fault_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fill_req_o,
  output logic [19:0] fill_vpn_o,
  output logic [21:0] fill_ppn_o,
  output logic [6:0]  fill_perm_o,
  output logic        fill_superpage_o
);

  typedef enum logic [1:0] {IDLE, L1, L0, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_n;
  logic [7:0]  tmo_q;
  logic [21:0] satp_q;
  logic [19:0] vpn_q;
  logic [19:0] ptr_ppn_q;
  logic [21:0] fill_ppn_q;
  logic [6:0]  fill_perm_q;
  logic        super_q;
  logic        fault_q;
  logic        store_q;

  logic [21:0] pte_ppn;
  logic        bad_root;
  logic        timed_out;
  logic        leaf_ok;
  logic        walk_ok;
  logic        unused_bits;

  function automatic logic pte_invalid(input logic [31:0] pte);
    return !pte[0] || (!pte[1] && pte[2]);
  endfunction

  function automatic logic pte_leaf(input logic [31:0] pte);
    return pte[1] || pte[3];
  endfunction

  function automatic logic ad_fault(input logic [31:0] pte, input logic store);
`ifdef SV32_PTW_AD_CHECK_EN
    return !pte[6] || (store && !pte[7]);
`else
    return 1'b0 & pte[6] & store;
`endif
  endfunction

  // RSW bits and the page offset never influence the walk
  assign unused_bits = ^{mem_rdata_i[9:8], walk_vaddr_i[11:0]};

  assign pte_ppn   = mem_rdata_i[31:10];
  assign bad_root  = satp_q[21:20] != 2'b00;
  assign timed_out = mem_req_o && !mem_ack_i && (tmo_q == TMO_LAST);
  assign leaf_ok   = !pte_invalid(mem_rdata_i) && pte_leaf(mem_rdata_i) &&
                     !ad_fault(mem_rdata_i, store_q);

  // A superpage leaf must be 4 MiB aligned; success only ever comes with an ack
  always_comb begin
    walk_ok = 1'b0;
    if (state_q == L1)
      walk_ok = mem_ack_i && !bad_root && leaf_ok && (mem_rdata_i[19:10] == 10'd0);
    else if (state_q == L0)
      walk_ok = mem_ack_i && leaf_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (walk_req_i && !flush_i) state_n = L1;
      L1: begin
        if (flush_i)        state_n = IDLE;
        else if (bad_root)  state_n = DONE;
        else if (mem_ack_i) begin
          if (!pte_invalid(mem_rdata_i) && !pte_leaf(mem_rdata_i) &&
              (pte_ppn[21:20] == 2'b00))
            state_n = L0;
          else
            state_n = DONE;
        end
        else if (timed_out) state_n = DONE;
      end
      L0: begin
        if (flush_i)                     state_n = IDLE;
        else if (mem_ack_i || timed_out) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    walk_busy_o = state_q != IDLE;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    if (state_q == L1) begin
      mem_req_o  = !bad_root;
      mem_addr_o = {satp_q[19:0], vpn_q[19:10], 2'b00};
    end else if (state_q == L0) begin
      mem_req_o  = 1'b1;
      mem_addr_o = {ptr_ppn_q, vpn_q[9:0], 2'b00};
    end
    walk_done_o  = (state_q == DONE) && !flush_i;
    walk_fault_o = walk_done_o && fault_q;
    fill_req_o   = walk_done_o && !fault_q;
  end

  assign fill_vpn_o       = vpn_q;
  assign fill_ppn_o       = fill_ppn_q;
  assign fill_perm_o      = fill_perm_q;
  assign fill_superpage_o = super_q;

  // Walk context, captured on acceptance and on each level transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      satp_q      <= '0;
      vpn_q       <= '0;
      store_q     <= 1'b0;
      ptr_ppn_q   <= '0;
      fill_ppn_q  <= '0;
      fill_perm_q <= '0;
      super_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && state_n == L1) begin
        satp_q  <= satp_ppn_i;
        vpn_q   <= walk_vaddr_i[31:12];
        store_q <= walk_store_i;
      end
      if (state_q == L1 && state_n == L0)
        ptr_ppn_q <= pte_ppn[19:0];
      if (state_q != DONE && state_n == DONE) begin
        fault_q     <= !walk_ok;
        fill_ppn_q  <= pte_ppn;
        fill_perm_q <= mem_rdata_i[7:1];
        super_q     <= state_q == L1;
      end
    end
  end

  // Timeout counter restarts on every level entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_q <= '0;
    else if ((state_n == L1 || state_n == L0) && state_n != state_q)
      tmo_q <= '0;
    else if (mem_req_o && !mem_ack_i)
      tmo_q <= tmo_q + 8'd1;
  end

endmodule

// File: tb/tb_sv32_ptw.sv
// Randomized bench for sv32_ptw against a behavioural Sv32 translation model.
module tb_sv32_ptw;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] satp_ppn_i;
  logic        walk_req_i;
  logic [31:0] walk_vaddr_i;
  logic        walk_store_i;
  logic        flush_i;
  logic        walk_busy_o, walk_done_o, walk_fault_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        fill_req_o;
  logic [19:0] fill_vpn_o;
  logic [21:0] fill_ppn_o;
  logic [6:0]  fill_perm_o;
  logic        fill_superpage_o;

  int n_cmp = 0;
  int n_bad = 0;

  sv32_ptw #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .satp_ppn_i(satp_ppn_i), .walk_req_i(walk_req_i),
    .walk_vaddr_i(walk_vaddr_i), .walk_store_i(walk_store_i), .flush_i(flush_i),
    .walk_busy_o(walk_busy_o), .walk_done_o(walk_done_o), .walk_fault_o(walk_fault_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .fill_req_o(fill_req_o), .fill_vpn_o(fill_vpn_o),
    .fill_ppn_o(fill_ppn_o), .fill_perm_o(fill_perm_o), .fill_superpage_o(fill_superpage_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sv32 translation as the privileged architecture describes it, with wait states
  task automatic model(input logic [21:0] satp, input logic [31:0] va, input logic st,
                       input logic [31:0] p1, input logic [31:0] p0, input int w1, input int w0,
                       output int n, output logic [31:0] a0, output logic [31:0] a1,
                       output logic flt, output logic [21:0] fppn, output logic [6:0] fperm,
                       output logic fsup, output int lat);
    logic [21:0] a;
    logic [31:0] pte, addr;
    logic [9:0]  vpn;
    int          w;
    n = 0; a0 = 0; a1 = 0; flt = 0; fppn = 0; fperm = 0; fsup = 0; lat = 1;
    a = satp;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      if (a[21:20] != 2'b00) begin
        flt = 1;
        if (lvl == 1) lat += 1;
        break;
      end
      vpn  = (lvl == 1) ? va[31:22] : va[21:12];
      addr = {a[19:0], vpn, 2'b00};
      if (n == 0) a0 = addr; else a1 = addr;
      n++;
      w   = (lvl == 1) ? w1 : w0;
      pte = (lvl == 1) ? p1 : p0;
      if (w >= TIMEOUT) begin
        flt = 1;
        lat += TIMEOUT;
        break;
      end
      lat += w + 1;
      if (!pte[0] || (!pte[1] && pte[2])) begin
        flt = 1;
        break;
      end
      if (pte[1] || pte[3]) begin
        if (lvl == 1 && pte[19:10] != 0) flt = 1;
`ifdef SV32_PTW_AD_CHECK_EN
        if (!pte[6] || (st && !pte[7])) flt = 1;
`endif
        if (!flt) begin
          fppn  = pte[31:10];
          fperm = pte[7:1];
          fsup  = (lvl == 1);
        end
        break;
      end
      if (lvl == 0) begin
        flt = 1;
        break;
      end
      a = pte[31:10];
    end
  endtask

  // Entered and left at #1 after a rising edge, with the DUT idle
  task automatic run_walk(input logic [21:0] satp, input logic [31:0] va, input logic st,
                          input logic [31:0] p1, input logic [31:0] p0, input int w1,
                          input int w0, input int flush_after, input string tag);
    int en, elat, cyc, nst, rcyc, wleft;
    logic [31:0] ea0, ea1;
    logic eflt, esup, done, flushed, inrd, seen;
    logic [21:0] eppn;
    logic [6:0]  eperm;
    model(satp, va, st, p1, p0, w1, w0, en, ea0, ea1, eflt, eppn, eperm, esup, elat);
    satp_ppn_i = satp; walk_vaddr_i = va; walk_store_i = st; walk_req_i = 1'b1;
    @(posedge clk); #1;
    walk_req_i = 1'b0;
    satp_ppn_i = 22'($urandom); walk_vaddr_i = $urandom; walk_store_i = 1'($urandom);
    cyc = 1; nst = 0; rcyc = 0; wleft = 0; done = 0; flushed = 0; inrd = 0;
    while (!done && !flushed && cyc < 400) begin
      mem_ack_i = 1'b0; mem_rdata_i = $urandom; flush_i = 1'b0;
      if (mem_req_o) begin
        if (!inrd) begin
          inrd = 1; rcyc = 0;
          wleft = (nst == 0) ? w1 : w0;
          chk({tag, ".addr"}, mem_addr_o, (nst == 0) ? ea0 : ea1);
          nst++;
        end
        rcyc++;
        if (flush_after >= 0 && nst == 2 && rcyc == flush_after + 1) begin
          flush_i = 1'b1; flushed = 1;
        end else if (wleft == 0) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = (nst == 1) ? p1 : p0;
          inrd = 0;
        end else begin
          wleft--;
        end
      end
      #1;
      if (walk_done_o) begin
        done = 1;
        chk({tag, ".lat"}, cyc, elat);
        chk({tag, ".reads"}, nst, en);
        chk({tag, ".busy"}, walk_busy_o, 1'b1);
        chk({tag, ".fault"}, walk_fault_o, eflt);
        chk({tag, ".fill"}, fill_req_o, !eflt);
        if (!eflt) begin
          chk({tag, ".vpn"}, fill_vpn_o, va[31:12]);
          chk({tag, ".ppn"}, fill_ppn_o, eppn);
          chk({tag, ".perm"}, fill_perm_o, eperm);
          chk({tag, ".super"}, fill_superpage_o, esup);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack_i = 1'b0; flush_i = 1'b0;
    if (flush_after >= 0) chk({tag, ".flush_hit"}, flushed, 1'b1);
    if (flushed) begin
      chk({tag, ".flush_idle"}, walk_busy_o, 1'b0);
      seen = 0;
      repeat (4) begin
        seen |= walk_done_o | fill_req_o | walk_fault_o | mem_req_o;
        @(posedge clk); #1;
      end
      chk({tag, ".flush_quiet"}, seen, 1'b0);
    end else begin
      chk({tag, ".done"}, done, 1'b1);
    end
  endtask

  function automatic logic [31:0] rand_ptr();
    logic [21:0] ppn;
    logic [7:0]  fl;
    ppn = ($urandom % 8 == 0) ? 22'($urandom) : {2'b00, 20'($urandom % 4096)};
    fl  = (8'($urandom) & 8'hF1) | 8'h01;
    return {ppn, 2'($urandom), fl};
  endfunction

  function automatic logic [31:0] rand_leaf(input logic aligned);
    logic [21:0] ppn;
    logic [7:0]  fl;
    ppn = 22'($urandom);
    if (aligned) ppn[9:0] = 10'd0;
    fl = 8'($urandom) | 8'h03;
    return {ppn, 2'($urandom), fl};
  endfunction

  initial begin
    logic [31:0] p1, p0;
    logic [21:0] satp;
    int          k1, k0;
    rst_n = 1'b0; satp_ppn_i = '0; walk_req_i = 1'b0; walk_vaddr_i = '0;
    walk_store_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy_done_fault", {walk_busy_o, walk_done_o, walk_fault_o}, 3'b000);
    chk("rst.mem", {mem_req_o, mem_addr_o}, 33'd0);
    chk("rst.fill", {fill_req_o, fill_superpage_o, fill_perm_o}, 9'd0);
    chk("rst.fill_vpn", fill_vpn_o, 20'd0);
    chk("rst.fill_ppn", fill_ppn_o, 22'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00020401, 32'h00048CC7, 0, 0, -1, "ex4k");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h200000CF, 32'h0, 0, 0, -1, "exsuper");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00000C0F, 32'h0, 0, 0, -1, "exmisal");
    run_walk(22'h80, 32'h00401123, 1'b1, 32'h00020401, 32'h00048C87, 0, 0, -1, "exnoA");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00020401, 32'h0, 1000, 0, -1, "extmo");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00020401, 32'h00048CC7, 0, 10, 3, "exflush");
    run_walk(22'h300080, 32'h00401123, 1'b0, 32'h0, 32'h0, 0, 0, -1, "badroot");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h10000001, 32'h0, 0, 0, -1, "badptr");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00020401, 32'h00030401, 2, 1, -1, "l0ptr");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00020405, 32'h0, 0, 0, -1, "invw");
    run_walk(22'h80, 32'h00401123, 1'b0, 32'h00020401, 32'h00048CC7, 0, 1000, -1, "tmo0");

    // A request together with a flush in IDLE is dropped
    walk_req_i = 1'b1; flush_i = 1'b1; walk_vaddr_i = 32'h1234_5000; satp_ppn_i = 22'h80;
    @(posedge clk); #1;
    walk_req_i = 1'b0; flush_i = 1'b0;
    chk("idleflush.busy", walk_busy_o, 1'b0);

    // Reset in the middle of a walk abandons it at once
    walk_req_i = 1'b1; walk_vaddr_i = 32'h0040_1000; satp_ppn_i = 22'h80;
    @(posedge clk); #1;
    walk_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.req_before", mem_req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.state", {walk_busy_o, mem_req_o, walk_done_o, fill_req_o}, 4'b0000);
    chk("midrst.addr", mem_addr_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 70; k++) begin
      satp = ($urandom % 12 == 0) ? 22'($urandom) : 22'($urandom % 4096);
      k1 = $urandom % 6;
      case (k1)
        0, 1, 2: p1 = rand_ptr();
        3:       p1 = rand_leaf(1'b1);
        4:       p1 = rand_leaf(1'b0);
        default: p1 = $urandom;
      endcase
      k0 = $urandom % 5;
      case (k0)
        0, 1, 2: p0 = rand_leaf(1'b0);
        3:       p0 = rand_ptr();
        default: p0 = $urandom;
      endcase
      run_walk(satp, $urandom, 1'($urandom), p1, p0,
               ($urandom % 3 == 0) ? $urandom % 5 : 0,
               ($urandom % 3 == 0) ? $urandom % 5 : 0,
               -1, $sformatf("r%0d", k));
      if ($urandom % 3 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sv32_ptw.md
SV32_PTW -- requirements
Module: sv32_ptw

Interface
REQ-001 Parameter: TIMEOUT, default 64, range 1..255; max cycles mem_req_o may stay asserted without mem_ack_i before the walk faults.
REQ-002 clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 satp_ppn_i  input  22  root page-table PPN; sampled when a walk is accepted.
REQ-005 walk_req_i  input  1  start a walk on a TLB miss; accepted only in IDLE.
REQ-006 walk_vaddr_i  input  32  missing virtual address; sampled with walk_req_i.
REQ-007 walk_store_i  input  1  access is a store; sampled with walk_req_i.
REQ-008 flush_i  input  1  SFENCE.VMA; aborts any walk in progress.
REQ-009 walk_busy_o  output  1  high in every state except IDLE.
REQ-010 walk_done_o  output  1  one-cycle pulse when a walk completes.
REQ-011 walk_fault_o  output  1  page-fault flag; valid only while walk_done_o is high.
REQ-012 mem_req_o / mem_addr_o  output  1/32  PTE read request and word address; held stable until mem_ack_i.
REQ-013 mem_ack_i / mem_rdata_i  input  1/32  read accepted; the PTE is valid in the same cycle as mem_ack_i.
REQ-014 fill_req_o  output  1  TLB fill strobe; one-cycle pulse.
REQ-015 fill_vpn_o  output  20  VPN to fill, equal to vaddr[31:12].
REQ-016 fill_ppn_o  output  22  PPN to fill.
REQ-017 fill_perm_o  output  7  permissions to fill, {D,A,G,U,X,W,R} = pte[7:1].
REQ-018 fill_superpage_o  output  1  entry is a 4 MiB superpage.

Function
REQ-019 FSM states: IDLE, L1, L0, DONE; walk_req_i accepted in IDLE moves to L1 on the next edge; walk_req_i is ignored in any other state.
REQ-020 L1 address = {satp_ppn[19:0], vaddr[31:22], 2'b00}.
REQ-021 L0 address = {pte1.ppn[19:0], vaddr[21:12], 2'b00}.
REQ-022 If the PPN used to form an address has bits [21:20] nonzero, the walk faults without issuing that read.
REQ-023 mem_req_o is high in L1/L0 from entry until the cycle of mem_ack_i inclusive; the PTE is decoded in the mem_ack_i cycle.
REQ-024 PTE decode: invalid if V=0, or R=0 with W=1; leaf if R or X is set; otherwise the PTE is a pointer.
REQ-025 L1 pointer -> L0; L1 leaf with ppn[9:0]!=0 (misaligned) -> fault; L1 leaf with aligned ppn -> DONE as a superpage.
REQ-026 L0 leaf -> DONE; L0 pointer -> fault; an invalid PTE at either level -> fault.
REQ-027 In DONE, for one cycle, walk_done_o=1; the block returns to IDLE on the next edge.
REQ-028 On success, fill_req_o=1 in that same cycle, with fill_vpn_o=vaddr[31:12], fill_ppn_o=pte.ppn and fill_perm_o=pte[7:1].
REQ-029 On fault, walk_fault_o=1 and fill_req_o=0 in that DONE cycle.
REQ-030 Latency with zero-wait memory: a 4 KiB walk pulses done 3 cycles after the accepted request; a superpage walk pulses done 2 cycles after it.
REQ-031 The timeout counter clears on entry to L1/L0 and increments each cycle mem_req_o is high without mem_ack_i.
REQ-032 When the timeout counter reaches TIMEOUT, the walk goes to DONE with a fault and mem_req_o drops.
REQ-033 flush_i in L1, L0 or DONE: next state IDLE; no done, fill or fault pulse; mem_req_o drops without waiting for ack.
REQ-034 flush_i has priority over a same-cycle mem_ack_i.
REQ-035 flush_i in IDLE together with walk_req_i: the request is dropped.
REQ-036 A walk_req_i in the cycle after DONE is accepted normally.

Reset
REQ-037 While rst_n=0: FSM in IDLE, all outputs 0, timeout counter 0, captured vaddr/PPN registers 0; deassertion takes effect at the next clock edge.
REQ-038 Reset asserted mid-walk abandons the walk immediately, with no fill.

Configuration
REQ-039 With SV32_PTW_AD_CHECK_EN defined: a leaf with A=0, or a leaf with D=0 when walk_store_i=1, faults.
REQ-040 With SV32_PTW_AD_CHECK_EN undefined: A and D bits are not checked and are passed through to fill_perm_o.

Verification
REQ-041 satp_ppn=0x80, vaddr=0x00401123, zero-wait memory; L1 read returns 0x00020401, L0 read returns 0x00048CC7 -> mem_addr 0x00080004 then 0x00081004; fill vpn=0x00401, ppn=0x123, perm=0x63, superpage=0; done 3 cycles after request.
REQ-042 Same satp and vaddr, L1 read returns 0x200000CF -> a single read; fill ppn=0x80000, perm=0x67, superpage=1; done 2 cycles after request.
REQ-043 L1 read returns 0x00000C0F (misaligned superpage) -> done=1, fault=1, fill_req=0.
REQ-044 L0 read returns 0x00048C87 (A=0) -> fault with macro defined; with the macro undefined, fill with perm=0x43.
REQ-045 mem_ack_i held low -> fault pulse after 64 request cycles.
REQ-046 flush_i asserted during an L0 wait -> IDLE, with no done or fill pulse.
